// File: rtl/bcd_count_ctrl_if.sv
// Command and counter-side signals of the BCD counter sequencing controller.
//   master : software command side plus the counter digit (drives strobes,
//            dir/target and the counter's present value / ripple carry).
//   slave  : the controller (drives counter enable/direction/clear and the
//            busy/done/wrap status).
interface bcd_count_ctrl_if;
  logic       start_i;
  logic       stop_i;
  logic       clear_i;
  logic       dir_i;
  logic [3:0] target_i;
  logic [3:0] cnt_bcd_i;
  logic       cnt_rc_i;
  logic       cnt_enable_o;
  logic       cnt_updown_o;
  logic       cnt_clr_no;
  logic       busy_o;
  logic       done_o;
  logic       wrap_o;

  modport master (
    output start_i, stop_i, clear_i, dir_i, target_i, cnt_bcd_i, cnt_rc_i,
    input  cnt_enable_o, cnt_updown_o, cnt_clr_no, busy_o, done_o, wrap_o
  );

  modport slave (
    input  start_i, stop_i, clear_i, dir_i, target_i, cnt_bcd_i, cnt_rc_i,
    output cnt_enable_o, cnt_updown_o, cnt_clr_no, busy_o, done_o, wrap_o
  );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for a single-digit up/down BCD counter.
// Paces counting with a PRESCALE-cycle prescaler and runs a start/stop/clear
// command FSM (IDLE, RUN, PAUSE, CLR). Reports done when the digit reaches
// the latched target (up) or 0 (down), and wrap when the digit rolls 9->0.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of bcd_count_ctrl_if (commands in, counter controls
//            and status out)
module bcd_count_ctrl #(
  parameter int PRESCALE = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  bcd_count_ctrl_if.slave bus
);
  localparam int            PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_CLR} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          dir_q, dir_d;
  logic [3:0]    target_q, target_d;
  logic          done_q, done_d;
  logic          wrap_q;
  logic          clr_n_q;
  logic          tick;
  logic          match;
  logic [3:0]    term;

  assign tick  = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign term  = dir_q ? target_q : 4'd0;
  // Terminal is only evaluated on non-tick cycles, so the digit seen here is
  // always settled. A start with the digit already at term matches in the
  // first RUN cycle because pre_q is 0 there.
  assign match = (state_q == ST_RUN) && !tick && (bus.cnt_bcd_i == term);

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    dir_d    = dir_q;
    target_d = target_q;
    done_d   = 1'b0;
    if (state_q == ST_RUN) pre_d = tick ? '0 : pre_q + 1'b1;
    if (bus.clear_i) begin
      state_d = ST_CLR;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start_i) begin
          state_d  = ST_RUN;
          pre_d    = '0;
          dir_d    = bus.dir_i;
          target_d = (bus.target_i > 4'd9) ? 4'd9 : bus.target_i;
        end
        ST_RUN: begin
          if (match) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (bus.stop_i) begin
            state_d = ST_PAUSE;
          end
        end
        // Resume keeps the held prescaler and the latched dir/target.
        ST_PAUSE: if (bus.start_i) state_d = ST_RUN;
        ST_CLR:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      dir_q    <= 1'b1;
      target_q <= 4'd9;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      clr_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      dir_q    <= dir_d;
      target_q <= target_d;
      done_q   <= done_d;
      wrap_q   <= tick & bus.cnt_rc_i & dir_q;
      // Low exactly for the single CLR cycle.
      clr_n_q  <= (state_d != ST_CLR);
    end
  end

  assign bus.cnt_enable_o = tick;
  assign bus.cnt_updown_o = dir_q;
  assign bus.cnt_clr_no   = clr_n_q;
  assign bus.busy_o       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.done_o       = done_q;
  assign bus.wrap_o       = wrap_q;
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: a behavioural BCD digit plus a reference model
// expressed in elapsed-run-cycle arithmetic, compared every cycle, and
// directed scenarios with hand-computed timing expectations.
module tb_bcd_count_ctrl;
  localparam int P = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  bcd_count_ctrl_if bus ();

  bcd_count_ctrl #(.PRESCALE(P)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Behavioural counter digit: sync clear (ANDed with reset), 9->0 wrap up,
  // saturate at 0 down. load_en lets the bench preset the digit.
  logic [3:0] cnt;
  logic       load_en  = 1'b0;
  logic [3:0] load_val = 4'd0;
  always @(posedge clk_i) begin
    if (load_en)                         cnt <= load_val;
    else if (!(bus.cnt_clr_no && rst_ni)) cnt <= 4'd0;
    else if (bus.cnt_enable_o) begin
      if (bus.cnt_updown_o) cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
      else                  cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    end
  end
  assign bus.cnt_bcd_i = cnt;
  assign bus.cnt_rc_i  = bus.cnt_updown_o && (cnt == 4'd9);

  // Reference model: el counts RUN cycles since the last start-from-idle;
  // a tick is every P-th of those.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_CLR} mode_t;
  mode_t m;
  int    el;
  int    m_tgt;
  bit    m_dir, m_done, m_wrap;
  wire   m_tick  = (m == M_RUN) && ((el % P) == P - 1);
  wire   m_match = (m == M_RUN) && !m_tick && (int'(cnt) == (m_dir ? m_tgt : 0));

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m <= M_IDLE; el <= 0; m_dir <= 1'b1; m_tgt <= 9; m_done <= 1'b0; m_wrap <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_wrap <= m_tick && m_dir && (cnt == 4'd9);
      if (m == M_RUN) el <= el + 1;
      if (bus.clear_i) begin
        m <= M_CLR; el <= 0;
      end else begin
        case (m)
          M_IDLE: if (bus.start_i) begin
            m <= M_RUN; el <= 0; m_dir <= bus.dir_i;
            m_tgt <= (bus.target_i > 4'd9) ? 9 : int'(bus.target_i);
          end
          M_RUN: begin
            if (m_match) begin m <= M_IDLE; m_done <= 1'b1; end
            else if (bus.stop_i) m <= M_PAUSE;
          end
          M_PAUSE: if (bus.start_i) m <= M_RUN;
          default: m <= M_IDLE;
        endcase
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk_i);
      chk("enable", int'(bus.cnt_enable_o), int'(m_tick));
      chk("updown", int'(bus.cnt_updown_o), int'(m_dir));
      chk("clr_n",  int'(bus.cnt_clr_no),   int'(m != M_CLR));
      chk("busy",   int'(bus.busy_o),       int'(m == M_RUN || m == M_PAUSE));
      chk("done",   int'(bus.done_o),       int'(m_done));
      chk("wrap",   int'(bus.wrap_o),       int'(m_wrap));
    end
  endtask

  task automatic load(input logic [3:0] v);
    load_en = 1'b1; load_val = v;
    @(negedge clk_i);
    load_en = 1'b0;
  endtask

  // Strobe start so it is sampled at edge 0; returns at the negedge of cycle 1.
  task automatic go(input logic d, input logic [3:0] t);
    bus.start_i = 1'b1; bus.dir_i = d; bus.target_i = t;
    @(negedge clk_i);
    bus.start_i = 1'b0;
  endtask

  task automatic watch(input int budget, output int done_c, output int nt,
                       output int t1, output int t2, output int nw, output int wc);
    done_c = -1; nt = 0; t1 = -1; t2 = -1; nw = 0; wc = -1;
    for (int c = 1; c <= budget; c++) begin
      if (bus.cnt_enable_o) begin
        nt++;
        if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
      end
      if (bus.wrap_o) begin nw++; wc = c; end
      if (bus.done_o) begin done_c = c; break; end
      @(negedge clk_i);
    end
  endtask

  initial begin
    int dc, nt, t1, t2, nw, wc, pause_ticks, nd;
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.clear_i = 1'b0;
    bus.dir_i = 1'b1; bus.target_i = 4'd0;
    fork compare_loop(); join_none

    repeat (3) @(negedge clk_i);
    chk("rst_enable", int'(bus.cnt_enable_o), 0);
    chk("rst_updown", int'(bus.cnt_updown_o), 1);
    chk("rst_clr_n",  int'(bus.cnt_clr_no),   1);
    chk("rst_busy",   int'(bus.busy_o),       0);
    chk("rst_done",   int'(bus.done_o),       0);
    chk("rst_wrap",   int'(bus.wrap_o),       0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Count up 0 -> 2.
    load(4'd0);
    go(1'b1, 4'd2);
    watch(40, dc, nt, t1, t2, nw, wc);
    chk("up_tick1", t1, 4);
    chk("up_tick2", t2, 8);
    chk("up_ticks", nt, 2);
    chk("up_done",  dc, 10);
    chk("up_cnt",   int'(cnt), 2);
    @(negedge clk_i);

    // Up one step to 3, then down 3 -> 0.
    go(1'b1, 4'd3);
    watch(40, dc, nt, t1, t2, nw, wc);
    chk("up1_done", dc, 6);
    @(negedge clk_i);
    go(1'b0, 4'd5);
    watch(40, dc, nt, t1, t2, nw, wc);
    chk("dn_done",  dc, 14);
    chk("dn_ticks", nt, 3);
    chk("dn_wrap",  nw, 0);
    chk("dn_cnt",   int'(cnt), 0);
    @(negedge clk_i);

    // Wrap: 7 -> 8 -> 9 -> 0 -> 1.
    load(4'd7);
    go(1'b1, 4'd1);
    watch(40, dc, nt, t1, t2, nw, wc);
    chk("wr_done",  dc, 18);
    chk("wr_count", nw, 1);
    chk("wr_cycle", wc, 13);
    chk("wr_cnt",   int'(cnt), 1);
    @(negedge clk_i);

    // Clamped target with digit already at 9: immediate done.
    load(4'd9);
    go(1'b1, 4'd12);
    watch(10, dc, nt, t1, t2, nw, wc);
    chk("im_done",  dc, 2);
    chk("im_ticks", nt, 0);
    @(negedge clk_i);

    // Pause after 2 ticks for 20 cycles; dir/target changes ignored.
    load(4'd0);
    go(1'b1, 4'd4);
    dc = -1; nt = 0; pause_ticks = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.cnt_enable_o) begin
        nt++;
        if (c >= 10 && c <= 29) pause_ticks++;
      end
      if (c == 20) chk("pa_busy", int'(bus.busy_o), 1);
      if (bus.done_o) begin dc = c; break; end
      if (c == 9)  begin bus.stop_i = 1'b1; bus.dir_i = 1'b0; bus.target_i = 4'd0; end
      if (c == 10) bus.stop_i = 1'b0;
      if (c == 29) bus.start_i = 1'b1;
      if (c == 30) bus.start_i = 1'b0;
      @(negedge clk_i);
    end
    chk("pa_quiet", pause_ticks, 0);
    chk("pa_done",  dc, 38);
    chk("pa_cnt",   int'(cnt), 4);
    bus.dir_i = 1'b1;
    @(negedge clk_i);

    // Clear coincident with stop and terminal match.
    load(4'd0);
    go(1'b1, 4'd1);
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.done_o) nd++;
      if (c == 5) begin bus.clear_i = 1'b1; bus.stop_i = 1'b1; end
      if (c == 6) begin
        bus.clear_i = 1'b0; bus.stop_i = 1'b0;
        chk("cl_clr_low", int'(bus.cnt_clr_no), 0);
        chk("cl_busy",    int'(bus.busy_o),     0);
      end
      if (c == 7) begin
        chk("cl_clr_high", int'(bus.cnt_clr_no), 1);
        chk("cl_cnt",      int'(cnt), 0);
      end
      @(negedge clk_i);
    end
    chk("cl_no_done", nd, 0);

    // Async reset mid-run, down mode, during a tick cycle.
    load(4'd5);
    go(1'b0, 4'd0);
    repeat (3) @(negedge clk_i);
    chk("rr_pre_enable", int'(bus.cnt_enable_o), 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rr_enable", int'(bus.cnt_enable_o), 0);
    chk("rr_updown", int'(bus.cnt_updown_o), 1);
    chk("rr_busy",   int'(bus.busy_o),       0);
    chk("rr_clr_n",  int'(bus.cnt_clr_no),   1);
    chk("rr_done",   int'(bus.done_o),       0);
    chk("rr_wrap",   int'(bus.wrap_o),       0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (bus.done_o) nd++;
    end
    chk("rr_no_done", nd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Sequencing controller for a single-digit up/down BCD counter (enable, direction, 0–9 value, ripple-carry-on-9→0 wrap, saturating at 0 when counting down). It owns the counter's `enable`/`updown` controls and a synchronous clear strobe. It paces counting with a clock prescaler and runs a start/stop/clear command FSM. It reports completion when the digit reaches a programmed target (up) or 0 (down). It sits between software-visible command strobes and the counter digit.

## Interface
- PRESCALE, 10, clk_i cycles per count tick; legal range ≥2.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start (from IDLE) or resume (from PAUSE); 1-cycle strobe.
- stop_i  in  1  pause a running count; strobe.
- clear_i  in  1  abort and clear counter; strobe.
- dir_i  in  1  1 = count up to target, 0 = count down to 0; sampled on start from IDLE.
- target_i  in  4  up-mode terminal value; sampled on start from IDLE; values >9 clamp to 9.
- cnt_bcd_i  in  4  counter present value.
- cnt_rc_i  in  1  counter ripple carry.
- cnt_enable_o  out  1  counter enable; combinational, high only on tick cycles.
- cnt_updown_o  out  1  counter direction; registered latched dir.
- cnt_clr_no  out  1  counter clear, active-low; registered 1-cycle pulse. Integrator ANDs it with rst_ni.
- busy_o  out  1  state is RUN or PAUSE.
- done_o  out  1  1-cycle registered pulse on terminal reached.
- wrap_o  out  1  1-cycle registered pulse when counter wraps 9→0.

## Operation
- **States:** IDLE, RUN, PAUSE, CLR.
- **Latched terminal:**
  - term = target_q when dir_q = 1.
  - term = 0 when dir_q = 0.
- **Prescaler** pre_q, width $clog2(PRESCALE), counts 0..PRESCALE-1.
  - Advances only in RUN.
  - Wraps to 0 after PRESCALE-1.
  - Held in PAUSE.
  - Zeroed on entering RUN from IDLE and in CLR.
- **Tick:**
  - tick = (state==RUN) & (pre_q==PRESCALE-1).
  - cnt_enable_o = tick.
- **Terminal check:** performed in RUN on non-tick cycles only. Match when cnt_bcd_i == term.
- **Transitions** (priority clear > terminal > stop > start):
  - any state, clear_i → CLR.
  - CLR → IDLE unconditionally after 1 cycle. cnt_clr_no is low during the CLR cycle.
  - IDLE, start_i → RUN. Latch dir_i→dir_q and clamp(target_i)→target_q.
  - RUN, terminal match → IDLE; done_o = 1 in the first IDLE cycle.
  - RUN, stop_i (no match) → PAUSE.
  - PAUSE, start_i → RUN. Prescaler resumes from its held value; dir_q/target_q not re-latched.
  - PAUSE, stop_i → no effect. RUN/IDLE redundant strobes → no effect.
- **Terminal already met:** a start with the counter already at term yields done with no tick. No special casing is needed, because pre_q = 0 ≠ PRESCALE-1.
- **Up mode, cnt_bcd_i > target at start:** counting passes through 9→0 (wrap) and stops at target.
- **Down mode:** stops at 0. The counter saturation is never exercised.
- **wrap_o** = registered (cnt_enable_o & cnt_rc_i & cnt_updown_o).
- **Reset values:**
  - state IDLE, pre_q 0, dir_q 1, target_q 9.
  - cnt_enable_o 0, cnt_updown_o 1, cnt_clr_no 1.
  - busy_o 0, done_o 0, wrap_o 0.
- **Reset mid-RUN:** returns all of the above immediately (async). No done_o is produced.

## Timing
- Start sampled at edge 0 → RUN from cycle 1 with pre_q = 0.
- First tick is in cycle PRESCALE. The counter updates at the end of that cycle.
- For N steps to terminal, done_o is high in cycle N·PRESCALE+2; busy_o falls in the same cycle.
- Each PAUSE cycle adds one cycle to that latency.
- clear_i at edge k:
  - CLR in cycle k+1 (cnt_clr_no low, busy_o low).
  - IDLE in cycle k+2.
- done_o and wrap_o are never high for more than one consecutive cycle.

## Test plan
- **Count up:** PRESCALE=4, counter 0, start with dir=1, target=2 → enable high in cycles 4 and 8; done_o in cycle 10 only; counter = 2; busy_o high cycles 1–9.
- **Count down:** counter preloaded to 3 via up count, start with dir=0 → counts 3,2,1,0; done_o at 3·4+2 after start; no wrap_o.
- **Wrap:** counter at 7, start up with target=1 → ticks 7→8→9→0 (wrap_o once, cycle after the 9→0 tick) →1, done_o at 4·4+2.
- **Clamp / immediate done:** target_i = 12 with counter at 9 → done_o in cycle 2, zero ticks.
- **Pause/resume:**
  - Stop after 2 ticks → enable stays low through 20 PAUSE cycles; busy_o high.
  - start resumes → done delayed by exactly the pause length.
  - dir_i/target_i changes during PAUSE are ignored.
- **Clear and reset:**
  - clear_i coincident with stop_i and terminal match in RUN → CLR wins, no done_o, cnt_clr_no low one cycle, counter 0.
  - rst_ni low mid-RUN → all outputs at reset values asynchronously.
